// File: rtl/dir_hist_scan.sv
// Direction-histogram scanner: walks a 16x16 window through an external bin ROM,
// accumulates gradient magnitudes into 32 bins, then streams the bins out.
module dir_hist_scan #(
    parameter int MAG_W = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [7:0]       rom_a,
    input  logic [4:0]       rom_spo,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [MAG_W-1:0] pix_mag,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [4:0]       hist_bin,
    output logic [ACC_W-1:0] hist_data,
    output logic             hist_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_addr;
    logic [4:0]       r_idx;
    logic             r_done;
    logic [ACC_W-1:0] r_acc [32];

    logic             w_clr;
    logic             w_pix_acc;
    logic             w_hist_acc;
    logic             w_done;
    logic [ACC_W-1:0] w_mag_ext;

    assign w_mag_ext = {{(ACC_W-MAG_W){1'b0}}, pix_mag};

    always_comb begin
        w_next     = r_state;
        w_clr      = 1'b0;
        w_pix_acc  = 1'b0;
        w_hist_acc = 1'b0;
        w_done     = 1'b0;
        pix_ready  = 1'b0;
        hist_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = SCAN;
                end
            end
            SCAN: begin
                pix_ready = 1'b1;
                w_pix_acc = pix_valid;
                if (pix_valid && r_addr == 8'hFF) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                hist_valid = 1'b1;
                w_hist_acc = hist_ready;
                if (hist_ready && r_idx == 5'd31) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
            if (w_clr) begin
                r_addr <= '0;
                for (int i = 0; i < 32; i++) begin
                    r_acc[i] <= '0;
                end
            end else if (w_pix_acc) begin
                r_acc[rom_spo] <= r_acc[rom_spo] + w_mag_ext;
                r_addr         <= r_addr + 8'd1;
            end
            // index wraps 31 -> 0 on the last bin, so IDLE always sees bin 0
            if (w_pix_acc && r_addr == 8'hFF) begin
                r_idx <= '0;
            end else if (w_hist_acc) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign rom_a     = (r_state == SCAN) ? r_addr : 8'd0;
    assign hist_bin  = r_idx;
    assign hist_data = r_acc[r_idx];
    assign hist_last = hist_valid && (r_idx == 5'd31);
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
